scroll_tick_engine: RTL and testbench



---
 rtl/scroll_tick_engine.sv | 219 +++++++++++++++++++++
 tb/tb_scroll_tick_engine.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_tick_engine.sv
// scroll_tick_engine: turns interval-timer timeouts into scroll steps.
// Acks the timer over an Avalon-MM master, commits position per frame.
module scroll_tick_engine #(
    parameter int         POS_W           = 10,
    parameter int         LIMIT_DEFAULT   = 640,
    parameter int         STEP_DEFAULT    = 1,
    parameter logic [2:0] TMR_STATUS_ADDR = 3'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_irq,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic             tmr_waitrequest,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    input  logic             frame_start,
    output logic [POS_W-1:0] scroll_x,
    output logic             wrap_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_STEP
    } state_t;

    localparam logic [POS_W-1:0] LIMIT_RST = POS_W'(LIMIT_DEFAULT);
    localparam logic [POS_W-1:0] STEP_RST  = POS_W'(STEP_DEFAULT);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       control_q;
    logic [POS_W-1:0] step_q;
    logic [POS_W-1:0] limit_q;
    logic [POS_W-1:0] pos_q;
    logic             wrap_flag_q;

    logic             wr_en;
    logic             wr_ctrl;
    logic             wr_step;
    logic             wr_limit;
    logic             wr_pos;
    logic             wr_status;
    logic [POS_W-1:0] wr_val;
    logic             unused_wdata;

    logic [POS_W:0]   ext_pos;
    logic [POS_W:0]   ext_step;
    logic [POS_W:0]   ext_limit;
    logic [POS_W:0]   up_sum;
    logic [POS_W:0]   up_wrap;
    logic [POS_W:0]   dn_wrap;
    logic             step_ok;
    logic [POS_W-1:0] next_pos;
    logic             step_wrap;
    logic             do_step;
    logic [15:0]      rd_mux;

    assign wr_en        = chipselect & ~write_n;
    assign wr_ctrl      = wr_en && (address == 3'd0);
    assign wr_step      = wr_en && (address == 3'd1);
    assign wr_limit     = wr_en && (address == 3'd2);
    assign wr_pos       = wr_en && (address == 3'd3);
    assign wr_status    = wr_en && (address == 3'd4);
    assign wr_val       = writedata[POS_W-1:0];
    assign unused_wdata = ^writedata[15:POS_W];

    // Software position write overrides a coincident scroll step.
    assign do_step  = (state_q == S_STEP) && !wr_pos;
    assign wrap_irq = wrap_flag_q & control_q[2];

    // FSM state register; reset drops the master request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and timer-acknowledge master outputs.
    always_comb begin
        state_d        = state_q;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        unique case (state_q)
            S_IDLE: begin
                if (tick_irq && control_q[0]) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_STATUS_ADDR;
                if (!tmr_waitrequest) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Modular step arithmetic, one guard bit for the carry/borrow.
    always_comb begin
        ext_pos   = {1'b0, pos_q};
        ext_step  = {1'b0, step_q};
        ext_limit = {1'b0, limit_q};
        up_sum    = ext_pos + ext_step;
        up_wrap   = up_sum - ext_limit;
        dn_wrap   = ext_pos + ext_limit - ext_step;
        step_ok   = (limit_q != '0) && (step_q < limit_q);
        next_pos  = pos_q;
        step_wrap = 1'b0;
        if (step_ok) begin
            if (!control_q[1]) begin
                if (up_sum >= ext_limit) begin
                    next_pos  = up_wrap[POS_W-1:0];
                    step_wrap = 1'b1;
                end else begin
                    next_pos = up_sum[POS_W-1:0];
                end
            end else begin
                if (pos_q < step_q) begin
                    next_pos  = dn_wrap[POS_W-1:0];
                    step_wrap = 1'b1;
                end else begin
                    next_pos = pos_q - step_q;
                end
            end
        end
    end

    // Configuration registers written by the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_q <= 3'd0;
            step_q    <= STEP_RST;
            limit_q   <= LIMIT_RST;
        end else begin
            if (wr_ctrl) begin
                control_q <= writedata[2:0];
            end
            if (wr_step) begin
                step_q <= wr_val;
            end
            if (wr_limit) begin
                limit_q <= wr_val;
            end
        end
    end

    // Scroll position: software load, else one step per serviced tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else if (wr_pos) begin
            pos_q <= (wr_val >= limit_q) ? '0 : wr_val;
        end else if (do_step) begin
            pos_q <= next_pos;
        end
    end

    // Sticky wrap flag; a same-cycle wrap beats the software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_flag_q <= 1'b0;
        end else if (do_step && step_wrap) begin
            wrap_flag_q <= 1'b1;
        end else if (wr_status) begin
            wrap_flag_q <= 1'b0;
        end
    end

    // Tear-free commit: video sees the position only at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_x <= '0;
        end else if (frame_start) begin
            scroll_x <= pos_q;
        end
    end

    // Slave read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux = 16'd0;
        unique case (address)
            3'd0: rd_mux[2:0]       = control_q;
            3'd1: rd_mux[POS_W-1:0] = step_q;
            3'd2: rd_mux[POS_W-1:0] = limit_q;
            3'd3: rd_mux[POS_W-1:0] = pos_q;
            3'd4: rd_mux[1:0]       = {state_q != S_IDLE, wrap_flag_q};
            default: rd_mux = 16'd0;
        endcase
    end

    // Registered read data, one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 16'd0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_scroll_tick_engine.sv
// tb_scroll_tick_engine: directed scenarios for scroll_tick_engine.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_scroll_tick_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_irq = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_waitrequest = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        frame_start = 1'b0;
    logic [9:0]  scroll_x;
    logic        wrap_irq;

    int checks = 0;
    int errors = 0;
    int acks = 0;

    scroll_tick_engine dut (
        .clk            (clk),
        .reset          (reset),
        .tick_irq       (tick_irq),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_waitrequest(tmr_waitrequest),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .frame_start    (frame_start),
        .scroll_x       (scroll_x),
        .wrap_irq       (wrap_irq)
    );

    always #5 clk = ~clk;

    task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    // hook 1: POSITION=100 in the STEP cycle; hook 2: frame_start there.
    task automatic tick_service(input int hook);
        bit got;
        got = 1'b0;
        tick_irq = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (tmr_chipselect && !tmr_write_n && !tmr_waitrequest) begin
                got = 1'b1;
                checks++;
                if (tmr_address !== 3'd0 || tmr_writedata !== 16'd0) begin
                    errors++;
                    $display("FAIL tick_write addr=%0d data=%0h required addr=0 data=0",
                             tmr_address, tmr_writedata);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout no timer ack within 50 cycles");
            tick_irq = 1'b0;
            return;
        end
        acks++;
        @(negedge clk);
        tick_irq = 1'b0;
        if (hook == 1) begin
            address    = 3'd3;
            writedata  = 16'd100;
            chipselect = 1'b1;
            write_n    = 1'b0;
        end
        if (hook == 2) frame_start = 1'b1;
        @(negedge clk);
        chipselect  = 1'b0;
        write_n     = 1'b1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        checks++;
        if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 ||
            tmr_address !== 3'd0 || tmr_writedata !== 16'd0) begin
            errors++;
            $display("FAIL reset_master cs=%b wn=%b a=%0d d=%0h required 0 1 0 0",
                     tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
        checks++;
        if (scroll_x !== 10'd0 || wrap_irq !== 1'b0 || readdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs scroll_x=%0d wrap_irq=%b rd=%0d required 0 0 0",
                     scroll_x, wrap_irq, readdata);
        end
        csr_read(3'd0, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL reset_control got=%0d required 0", d);
        end
        csr_read(3'd1, d);
        checks++;
        if (d !== 16'd1) begin
            errors++;
            $display("FAIL reset_step got=%0d required 1", d);
        end
        csr_read(3'd2, d);
        checks++;
        if (d !== 16'd640) begin
            errors++;
            $display("FAIL reset_limit got=%0d required 640", d);
        end
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL reset_pos got=%0d required 0", d);
        end
        csr_read(3'd4, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL reset_status got=%0d required 0", d);
        end
    endtask

    task automatic test_basic_ticks();
        logic [15:0] d;
        int a0;
        a0 = acks;
        csr_write(3'd0, 16'd1);
        for (int k = 0; k < 3; k++) tick_service(0);
        checks++;
        if (acks - a0 !== 3) begin
            errors++;
            $display("FAIL basic_acks got=%0d required 3", acks - a0);
        end
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd3) begin
            errors++;
            $display("FAIL basic_pos got=%0d required 3", d);
        end
        checks++;
        if (scroll_x !== 10'd0) begin
            errors++;
            $display("FAIL basic_precommit scroll_x=%0d required 0", scroll_x);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (scroll_x !== 10'd3) begin
            errors++;
            $display("FAIL basic_commit scroll_x=%0d required 3", scroll_x);
        end
    endtask

    task automatic test_up_wrap();
        logic [15:0] d;
        csr_write(3'd3, 16'd638);
        csr_write(3'd1, 16'd5);
        tick_service(0);
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd3) begin
            errors++;
            $display("FAIL upwrap_pos got=%0d required 3", d);
        end
        csr_read(3'd4, d);
        checks++;
        if (d !== 16'd1) begin
            errors++;
            $display("FAIL upwrap_status got=%0d required 1", d);
        end
        checks++;
        if (wrap_irq !== 1'b0) begin
            errors++;
            $display("FAIL upwrap_irq_masked got=%b required 0", wrap_irq);
        end
        csr_write(3'd0, 16'd5);
        checks++;
        if (wrap_irq !== 1'b1) begin
            errors++;
            $display("FAIL upwrap_irq got=%b required 1", wrap_irq);
        end
        csr_write(3'd4, 16'd0);
        checks++;
        if (wrap_irq !== 1'b0) begin
            errors++;
            $display("FAIL upwrap_clear got=%b required 0", wrap_irq);
        end
    endtask

    task automatic test_down_wrap();
        logic [15:0] d;
        csr_write(3'd0, 16'd3);
        csr_write(3'd3, 16'd2);
        tick_service(0);
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd637) begin
            errors++;
            $display("FAIL downwrap_pos got=%0d required 637", d);
        end
        csr_read(3'd4, d);
        checks++;
        if (d !== 16'd1) begin
            errors++;
            $display("FAIL downwrap_status got=%0d required 1", d);
        end
        csr_write(3'd4, 16'd0);
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        csr_write(3'd0, 16'd1);
        csr_write(3'd1, 16'd1);
        csr_write(3'd3, 16'd10);
        tmr_waitrequest = 1'b1;
        tick_irq   = 1'b1;
        address    = 3'd4;
        chipselect = 1'b1;
        write_n    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (!(tmr_chipselect === 1'b1 && tmr_write_n === 1'b0 &&
                  tmr_address === 3'd0 && tmr_writedata === 16'd0)) bad++;
            if (c == 2) begin
                checks++;
                if (readdata !== 16'd2) begin
                    errors++;
                    $display("FAIL stall_busy status=%0d required 2", readdata);
                end
                address = 3'd3;
            end
            if (c == 5) tmr_waitrequest = 1'b0;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold unstable_cycles=%0d required 0", bad);
        end
        @(negedge clk);
        tick_irq = 1'b0;
        checks++;
        if (tmr_chipselect !== 1'b0 || readdata !== 16'd10) begin
            errors++;
            $display("FAIL stall_step cs=%b pos=%0d required cs=0 pos=10",
                     tmr_chipselect, readdata);
        end
        @(negedge clk);
        checks++;
        if (readdata !== 16'd10) begin
            errors++;
            $display("FAIL stall_pre pos=%0d required 10", readdata);
        end
        @(negedge clk);
        chipselect = 1'b0;
        checks++;
        if (readdata !== 16'd11 || tmr_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL stall_post pos=%0d cs=%b required 11 0",
                     readdata, tmr_chipselect);
        end
    endtask

    task automatic test_disabled();
        logic [15:0] d;
        int seen;
        int a0;
        seen = 0;
        csr_write(3'd0, 16'd0);
        tick_irq = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tmr_chipselect !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL disabled_ack cycles=%0d required 0", seen);
        end
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd11) begin
            errors++;
            $display("FAIL disabled_pos got=%0d required 11", d);
        end
        a0 = acks;
        csr_write(3'd0, 16'd1);
        tick_service(0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tmr_chipselect !== 1'b0) seen++;
        end
        checks++;
        if (acks - a0 !== 1 || seen !== 0) begin
            errors++;
            $display("FAIL enable_once acks=%0d extra=%0d required 1 0",
                     acks - a0, seen);
        end
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd12) begin
            errors++;
            $display("FAIL enable_pos got=%0d required 12", d);
        end
    endtask

    task automatic test_collisions();
        logic [15:0] d;
        int a0;
        csr_write(3'd3, 16'd50);
        tick_service(1);
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd100) begin
            errors++;
            $display("FAIL coll_poswrite got=%0d required 100", d);
        end
        csr_read(3'd4, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL coll_nowrap status=%0d required 0", d);
        end
        tick_service(2);
        checks++;
        if (scroll_x !== 10'd100) begin
            errors++;
            $display("FAIL coll_frame scroll_x=%0d required 100", scroll_x);
        end
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd101) begin
            errors++;
            $display("FAIL coll_frame_pos got=%0d required 101", d);
        end
        csr_write(3'd1, 16'd700);
        a0 = acks;
        tick_service(0);
        csr_read(3'd3, d);
        checks++;
        if (acks - a0 !== 1 || d !== 16'd101) begin
            errors++;
            $display("FAIL coll_bigstep acks=%0d pos=%0d required 1 101",
                     acks - a0, d);
        end
        checks++;
        if (scroll_x !== 10'd100) begin
            errors++;
            $display("FAIL coll_scroll_hold scroll_x=%0d required 100", scroll_x);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] d;
        csr_write(3'd3, 16'd640);
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL bound_pos640 got=%0d required 0", d);
        end
        csr_write(3'd3, 16'd639);
        csr_read(3'd3, d);
        checks++;
        if (d !== 16'd639) begin
            errors++;
            $display("FAIL bound_pos639 got=%0d required 639", d);
        end
        csr_write(3'd6, 16'hffff);
        csr_read(3'd5, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL bound_reserved got=%0d required 0", d);
        end
        csr_read(3'd0, d);
        checks++;
        if (d !== 16'd1) begin
            errors++;
            $display("FAIL bound_ctrl_kept got=%0d required 1", d);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [15:0] d;
        int a0;
        csr_write(3'd1, 16'd1);
        tmr_waitrequest = 1'b1;
        tick_irq = 1'b1;
        @(negedge clk);
        checks++;
        if (tmr_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL midack_enter cs=%b required 1", tmr_chipselect);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1) begin
            errors++;
            $display("FAIL midack_async cs=%b wn=%b required 0 1",
                     tmr_chipselect, tmr_write_n);
        end
        @(negedge clk);
        reset = 1'b0;
        tmr_waitrequest = 1'b0;
        a0 = acks;
        csr_write(3'd0, 16'd1);
        tick_service(0);
        csr_read(3'd3, d);
        checks++;
        if (acks - a0 !== 1 || d !== 16'd1) begin
            errors++;
            $display("FAIL midack_service acks=%0d pos=%0d required 1 1",
                     acks - a0, d);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_ticks();
        test_up_wrap();
        test_down_wrap();
        test_stall();
        test_disabled();
        test_collisions();
        test_boundaries();
        test_reset_mid_ack();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
